// File: rtl/arm_i2c_sequencer.sv
// rtl/arm_i2c_sequencer.sv - I2C command sequencer: chunked frame writes to boards, angle polling of sensors
// Drives one i2c_master through ena/addr/rw/data; retries on NACK or timeout, records per-target failures.
module arm_i2c_sequencer #(
  parameter int NUM_BOARDS     = 4,
  parameter int FRAME_WIDTH    = 88,
  parameter int NUM_SENSORS    = 2,
  parameter int MAX_RETRIES    = 2,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              write_frames,
  input  logic                              read_angles,
  input  logic [7*NUM_BOARDS-1:0]           board_ids,
  input  logic [FRAME_WIDTH*NUM_BOARDS-1:0] command_frames,
  input  logic [7*NUM_SENSORS-1:0]          sensor_ids,
  output logic                              i2c_ena,
  output logic [6:0]                        i2c_addr,
  output logic                              i2c_rw,
  output logic [31:0]                       i2c_data_wr,
  output logic [7:0]                        i2c_nbytes,
  input  logic                              i2c_busy,
  input  logic [7:0]                        i2c_byte_counter,
  input  logic                              i2c_ack_error,
  input  logic [31:0]                       i2c_data_rd,
  output logic                              done,
  output logic [12*NUM_SENSORS-1:0]         angles,
  output logic [NUM_BOARDS-1:0]             board_error,
  output logic [NUM_SENSORS-1:0]            sensor_error,
  output logic [15:0]                       retry_count
);

  localparam int CHUNKS = (FRAME_WIDTH + 23) / 24;
  localparam int PADW   = CHUNKS * 24;
  localparam logic [3:0]  LAST_B  = 4'(NUM_BOARDS - 1);
  localparam logic [3:0]  LAST_S  = 4'(NUM_SENSORS - 1);
  localparam logic [7:0]  LAST_C  = 8'(CHUNKS - 1);
  localparam logic [7:0]  MAX_T   = 8'(MAX_RETRIES);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_BOARDS-1:0]  ONE_B = 1;
  localparam logic [NUM_SENSORS-1:0] ONE_S = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_XFER, S_WAIT_DONE, S_RETRY, S_NEXT, S_DONE
  } state_t;

  state_t      state, next_state;
  logic        wr_pend, rd_pend, pass_rd, fail_q;
  logic [3:0]  idx_q;
  logic [7:0]  chunk_q, tries_q;
  logic [31:0] timer_q;

  logic             start_wr, start_rd, timeout, complete, fail_now, can_retry, last_item;
  logic [6:0]       board_addr, sensor_addr;
  logic [FRAME_WIDTH-1:0] frame_sel;
  logic [PADW-1:0]  frame_pad;
  logic [23:0]      chunk_bits;
  logic             unused_rd;

  assign unused_rd = ^i2c_data_rd[31:12];

  assign start_wr  = (state == S_IDLE) && wr_pend;
  assign start_rd  = (state == S_IDLE) && !wr_pend && rd_pend;
  assign timeout   = ((state == S_XFER) || (state == S_WAIT_DONE)) && (timer_q >= TO_LAST);
  assign complete  = (state == S_WAIT_DONE) && !i2c_busy;
  // A transfer that completes on its last allowed cycle counts as completed, not timed out.
  assign fail_now  = complete ? i2c_ack_error : timeout;
  assign can_retry = tries_q < MAX_T;
  assign last_item = pass_rd ? (idx_q == LAST_S) : ((idx_q == LAST_B) && (chunk_q == LAST_C));

  assign i2c_ena = (state == S_START) || (state == S_XFER);
  assign done    = (state == S_IDLE) && !wr_pend && !rd_pend;

  // Target selection for LOAD; frames are zero-padded up to a whole number of 24-bit chunks.
  always_comb begin
    board_addr  = '0;
    sensor_addr = '0;
    frame_sel   = '0;
    for (int b = 0; b < NUM_BOARDS; b++) begin
      if (idx_q == 4'(b)) begin
        board_addr = board_ids[7*b +: 7];
        frame_sel  = command_frames[FRAME_WIDTH*b +: FRAME_WIDTH];
      end
    end
    for (int s = 0; s < NUM_SENSORS; s++) begin
      if (idx_q == 4'(s)) sensor_addr = sensor_ids[7*s +: 7];
    end
    frame_pad = '0;
    frame_pad[FRAME_WIDTH-1:0] = frame_sel;
    chunk_bits = '0;
    for (int c = 0; c < CHUNKS; c++) begin
      if (chunk_q == 8'(c)) chunk_bits = frame_pad[24*c +: 24];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (wr_pend || rd_pend) next_state = S_LOAD;
      S_LOAD:      next_state = S_START;
      S_START:     next_state = S_XFER;
      S_XFER: begin
        if (timeout)                              next_state = can_retry ? S_RETRY : S_NEXT;
        else if (i2c_byte_counter >= i2c_nbytes)  next_state = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (complete && !i2c_ack_error) next_state = S_NEXT;
        else if (fail_now)              next_state = can_retry ? S_RETRY : S_NEXT;
      end
      S_RETRY:     next_state = S_START;
      S_NEXT:      next_state = last_item ? S_DONE : S_LOAD;
      S_DONE:      next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_pend      <= 1'b0;
      rd_pend      <= 1'b0;
      pass_rd      <= 1'b0;
      fail_q       <= 1'b0;
      idx_q        <= '0;
      chunk_q      <= '0;
      tries_q      <= '0;
      timer_q      <= '0;
      i2c_addr     <= '0;
      i2c_rw       <= 1'b0;
      i2c_data_wr  <= '0;
      i2c_nbytes   <= '0;
      angles       <= '0;
      board_error  <= '0;
      sensor_error <= '0;
      retry_count  <= '0;
    end else begin
      // A request arriving on the same cycle its pass starts is kept for another pass.
      wr_pend <= (wr_pend & ~start_wr) | write_frames;
      rd_pend <= (rd_pend & ~start_rd) | read_angles;
      case (state)
        S_IDLE: begin
          if (start_wr || start_rd) begin
            pass_rd <= start_rd;
            idx_q   <= '0;
            chunk_q <= '0;
            tries_q <= '0;
          end
          if (start_wr) board_error  <= '0;
          if (start_rd) sensor_error <= '0;
        end
        S_LOAD: begin
          if (pass_rd) begin
            i2c_addr    <= sensor_addr;
            i2c_rw      <= 1'b1;
            i2c_data_wr <= {8'h20, 24'h0};
            i2c_nbytes  <= 8'd2;
          end else begin
            i2c_addr    <= board_addr;
            i2c_rw      <= 1'b0;
            i2c_data_wr <= {chunk_q + 8'd1, chunk_bits};
            i2c_nbytes  <= 8'd3;
          end
        end
        S_START: timer_q <= '0;
        S_XFER, S_WAIT_DONE: begin
          timer_q <= timer_q + 32'd1;
          fail_q  <= fail_now;
          if (complete && !i2c_ack_error && pass_rd) begin
            for (int s = 0; s < NUM_SENSORS; s++) begin
              if (idx_q == 4'(s)) angles[12*s +: 12] <= i2c_data_rd[11:0];
            end
          end
        end
        S_RETRY: begin
          tries_q <= tries_q + 8'd1;
          if (retry_count != 16'hFFFF) retry_count <= retry_count + 16'd1;
        end
        S_NEXT: begin
          tries_q <= '0;
          if (fail_q) begin
            if (pass_rd) sensor_error <= sensor_error | (ONE_S << idx_q);
            else         board_error  <= board_error | (ONE_B << idx_q);
          end
          if (pass_rd || chunk_q == LAST_C) begin
            chunk_q <= '0;
            idx_q   <= idx_q + 4'd1;
          end else begin
            chunk_q <= chunk_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_i2c_sequencer.sv
// tb/tb_arm_i2c_sequencer.sv - scoreboard bench for arm_i2c_sequencer with a behavioural i2c_master/slave model
module tb_arm_i2c_sequencer;
  localparam int NB = 4, FW = 88, NS = 2, MR = 2, TO = 40;

  logic            clock = 1'b0, reset = 1'b1, write_frames = 1'b0, read_angles = 1'b0;
  logic [7*NB-1:0] board_ids;
  logic [FW*NB-1:0] command_frames;
  logic [7*NS-1:0] sensor_ids;
  logic            i2c_ena, i2c_rw, i2c_busy, i2c_ack_error, done;
  logic [6:0]      i2c_addr;
  logic [31:0]     i2c_data_wr, i2c_data_rd;
  logic [7:0]      i2c_nbytes, i2c_byte_counter;
  logic [12*NS-1:0] angles;
  logic [NB-1:0]   board_error;
  logic [NS-1:0]   sensor_error;
  logic [15:0]     retry_count;

  always #5 clock = ~clock;

  arm_i2c_sequencer #(.NUM_BOARDS(NB), .FRAME_WIDTH(FW), .NUM_SENSORS(NS),
                      .MAX_RETRIES(MR), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .write_frames(write_frames), .read_angles(read_angles),
    .board_ids(board_ids), .command_frames(command_frames), .sensor_ids(sensor_ids),
    .i2c_ena(i2c_ena), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw), .i2c_data_wr(i2c_data_wr),
    .i2c_nbytes(i2c_nbytes), .i2c_busy(i2c_busy), .i2c_byte_counter(i2c_byte_counter),
    .i2c_ack_error(i2c_ack_error), .i2c_data_rd(i2c_data_rd), .done(done), .angles(angles),
    .board_error(board_error), .sensor_error(sensor_error), .retry_count(retry_count));

  typedef struct {
    logic [6:0]  addr;
    logic        rw;
    logic [31:0] data;
    logic [7:0]  nb;
  } xfer_t;

  xfer_t exp_q[$];
  int total = 0, bad = 0;
  int xfer_seen = 0, done_rises = 0, max_len = 0;
  logic [6:0]  nack_addr = 7'h7F, stuck_addr = 7'h7F;
  logic [31:0] rd0 = 32'h0, rd1 = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hand-derived chunks: frame 0 is the reference frame, frame b>0 is 11 copies of byte 0x11*b.
  function automatic xfer_t wr_exp(input int b, input int c);
    xfer_t e;
    logic [23:0] f0 [4];
    logic [7:0]  bv;
    f0[0] = 24'h99AABB; f0[1] = 24'h667788; f0[2] = 24'h334455; f0[3] = 24'h001122;
    bv = 8'(17 * b);
    e.addr = 7'(16 + b);
    e.rw   = 1'b0;
    e.nb   = 8'd3;
    if (b == 0)      e.data = {8'(c + 1), f0[c]};
    else if (c == 3) e.data = {8'(c + 1), 8'h00, bv, bv};
    else             e.data = {8'(c + 1), bv, bv, bv};
    return e;
  endfunction

  task automatic push_wr(input int bad_b);
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < 4; c++)
        repeat ((b == bad_b) ? 3 : 1) exp_q.push_back(wr_exp(b, c));
  endtask

  task automatic push_rd(input int bad_s);
    xfer_t e;
    for (int s = 0; s < NS; s++) begin
      e.addr = 7'(48 + s); e.rw = 1'b1; e.data = 32'h2000_0000; e.nb = 8'd2;
      repeat ((s == bad_s) ? 3 : 1) exp_q.push_back(e);
    end
  endtask

  task automatic pulse(input logic w, input logic r);
    @(negedge clock); write_frames = w; read_angles = r;
    @(negedge clock); write_frames = 1'b0; read_angles = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while (!done && n < limit) begin @(negedge clock); n++; end
    chk({name, "_done"}, done, 1);
    chk({name, "_queue_left"}, exp_q.size(), 0);
  endtask

  // Slave model: a new transfer starts on each ena rise; one byte every two cycles; busy falls once ena drops.
  initial begin
    logic ena_d, stuck;
    int tick;
    logic [7:0] nb;
    i2c_busy = 0; i2c_byte_counter = 0; i2c_ack_error = 0; i2c_data_rd = 0;
    ena_d = 0; stuck = 0; tick = 0; nb = 0;
    forever begin
      @(posedge clock); #1;
      if (reset) begin
        i2c_busy = 0; i2c_byte_counter = 0; i2c_ack_error = 0; ena_d = 0;
      end else begin
        if (i2c_ena && !ena_d) begin
          i2c_busy = 1; i2c_byte_counter = 0; tick = 0; nb = i2c_nbytes;
          i2c_ack_error = (i2c_addr == nack_addr);
          stuck = (i2c_addr == stuck_addr);
          i2c_data_rd = (i2c_addr == 7'h30) ? rd0 : (i2c_addr == 7'h31) ? rd1 : 32'hDEAD_0000;
        end else if (i2c_busy && !stuck) begin
          if (i2c_byte_counter < nb) begin
            tick++;
            if (tick % 2 == 0) i2c_byte_counter = i2c_byte_counter + 8'd1;
          end else if (!i2c_ena) begin
            i2c_busy = 0; i2c_byte_counter = 0;
          end
        end
        ena_d = i2c_ena;
      end
    end
  end

  // Monitor: every ena rise is one transfer attempt, checked against the head of the scoreboard.
  initial begin
    logic ena_p, done_p;
    int len;
    xfer_t e;
    ena_p = 0; done_p = 1; len = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        ena_p = 0; len = 0;
      end else begin
        if (i2c_ena && !ena_p) begin
          xfer_seen++;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_xfer: got addr=%h data=%h expected none", i2c_addr, i2c_data_wr);
          end else begin
            e = exp_q.pop_front();
            chk("xfer", {i2c_addr, i2c_rw, i2c_data_wr, i2c_nbytes}, {e.addr, e.rw, e.data, e.nb});
          end
        end
        if (i2c_ena) len++;
        else begin
          if (ena_p && len > max_len) max_len = len;
          len = 0;
        end
        ena_p = i2c_ena;
      end
      if (done && !done_p) done_rises++;
      done_p = done;
    end
  end

  initial begin
    int base, n;
    logic [7:0] bv;
    command_frames = '0;
    command_frames[0 +: FW] = 88'h11_2233_4455_6677_8899_AABB;
    for (int b = 0; b < NB; b++) begin
      board_ids[7*b +: 7] = 7'(16 + b);
      bv = 8'(17 * b);
      if (b > 0) command_frames[FW*b +: FW] = {11{bv}};
    end
    sensor_ids = {7'h31, 7'h30};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ena", i2c_ena, 0);
    chk("rst_done", done, 1);
    chk("rst_bus", {i2c_addr, i2c_rw, i2c_data_wr, i2c_nbytes}, 0);
    chk("rst_status", {angles, board_error, sensor_error, retry_count}, 0);

    // Ideal write of all four boards.
    done_rises = 0;
    push_wr(-1);
    pulse(1, 0);
    wait_done("write", 2000);
    chk("write_done_rises", done_rises, 1);
    chk("write_board_error", board_error, 0);
    chk("write_retry", retry_count, 0);

    // Angle poll; only the low 12 bits of read data are kept.
    rd0 = 32'h5A5A_0ABC; rd1 = 32'h0000_0123;
    push_rd(-1);
    pulse(0, 1);
    wait_done("read", 500);
    chk("read_angles", angles, 24'h123ABC);
    chk("read_sensor_error", sensor_error, 0);

    // Board 2 NACKs everything: three tries per chunk.
    nack_addr = 7'h12;
    push_wr(2);
    pulse(1, 0);
    wait_done("nack", 3000);
    chk("nack_board_error", board_error, 4'b0100);
    chk("nack_retry", retry_count, 8);
    nack_addr = 7'h7F;

    // Board 1 holds busy forever: every attempt ends by timeout.
    stuck_addr = 7'h11; max_len = 0;
    push_wr(1);
    pulse(1, 0);
    wait_done("stuck", 3000);
    chk("stuck_board_error", board_error, 4'b0010);
    chk("stuck_retry", retry_count, 16);
    chk("stuck_ena_len", (max_len >= TO) && (max_len <= TO + 1), 1);
    stuck_addr = 7'h7F;

    // Combined request plus a repeat read mid-pass; sensor 1 NACKs and keeps its old angle.
    nack_addr = 7'h31; rd0 = 32'h0000_0456; rd1 = 32'h0000_0777;
    done_rises = 0;
    push_wr(-1);
    push_rd(1);
    base = xfer_seen;
    pulse(1, 1);
    n = 0;
    while (xfer_seen < base + 3 && n < 500) begin @(negedge clock); n++; end
    chk("combo_progress", xfer_seen >= base + 3, 1);
    pulse(0, 1);
    wait_done("combo", 3000);
    chk("combo_done_rises", done_rises, 1);
    chk("combo_board_error", board_error, 0);
    chk("combo_sensor_error", sensor_error, 2'b10);
    chk("combo_angles", angles, 24'h123456);
    chk("combo_retry", retry_count, 18);
    nack_addr = 7'h7F;

    // Reset during the fifth transfer, then a fresh write from board 0 chunk 0.
    push_wr(-1);
    base = xfer_seen;
    pulse(1, 0);
    n = 0;
    while (xfer_seen < base + 5 && n < 500) begin @(negedge clock); n++; end
    @(negedge clock);
    chk("pre_reset_ena", i2c_ena, 1);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clock);
    chk("mid_rst_ena", i2c_ena, 0);
    chk("mid_rst_done", done, 1);
    chk("mid_rst_bus", {i2c_addr, i2c_rw, i2c_data_wr, i2c_nbytes}, 0);
    chk("mid_rst_status", {angles, board_error, sensor_error, retry_count}, 0);
    reset = 1'b0;
    push_wr(-1);
    pulse(1, 0);
    wait_done("restart", 2000);
    chk("restart_board_error", board_error, 0);
    chk("restart_retry", retry_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
